// File: rtl/mem_wb_reg_pkg.sv
// Shared MEM/WB definitions: load-type codes, default widths, load classifier.
package mem_wb_reg_pkg;

  localparam int WIDTH_INSTR = 8;
  localparam int WIDTH_LDT   = 3;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_W    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_HU   = 3'd3;
  localparam logic [2:0] LD_B    = 3'd4;
  localparam logic [2:0] LD_BU   = 3'd5;

  // Codes 6/7 are reserved and behave like LD_NONE.
  function automatic logic is_load(input logic [2:0] ldt);
    return (ldt >= LD_W) && (ldt <= LD_BU);
  endfunction

endpackage

// File: rtl/mem_wb_reg_load_ext.sv
// Load alignment and sign/zero extension with misalignment detection.
module mem_wb_reg_load_ext
  import mem_wb_reg_pkg::*;
#(
  parameter int LDT_W = WIDTH_LDT
) (
  input  logic [31:0]      word,
  input  logic [1:0]       addr,
  input  logic [LDT_W-1:0] loadType,
  output logic [31:0]      ext,
  output logic             misaligned
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  assign half     = addr[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[8*addr +: 8];

  // Select and extend the addressed lane; flag illegal word/halfword alignment.
  always_comb begin
    ext        = 32'd0;
    misaligned = 1'b0;
    case (loadType)
      LDT_W'(LD_W): begin
        ext        = word;
        misaligned = (addr != 2'd0);
      end
      LDT_W'(LD_H): begin
        ext        = {{16{half[15]}}, half};
        misaligned = addr[0];
      end
      LDT_W'(LD_HU): begin
        ext        = {16'd0, half};
        misaligned = addr[0];
      end
      LDT_W'(LD_B):  ext = {{24{byte_sel[7]}}, byte_sel};
      LDT_W'(LD_BU): ext = {24'd0, byte_sel};
      default:       ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load extension, write-back select, retire counter.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int INSTR_W = WIDTH_INSTR,
  parameter int LDT_W   = WIDTH_LDT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_MEM,
  input  logic [31:0]        PC_MEM,
  input  logic               valid_MEM,
  input  logic [31:0]        memAddr_MEM,
  input  logic [31:0]        memReadData_MEM,
  input  logic [LDT_W-1:0]   loadType_MEM,
  input  logic [4:0]         regWriteAddr_MEM,
  input  logic [31:0]        regWriteData_MEM,
  output logic [INSTR_W-1:0] instr_WB,
  output logic [31:0]        PC_WB,
  output logic               valid_WB,
  output logic [31:0]        memReadData_WB,
  output logic [4:0]         regWriteAddr_WB,
  output logic [31:0]        regWriteData_WB,
  output logic               excAdEL_WB,
  output logic [31:0]        retireCnt
);

  logic [31:0] ext;
  logic        mis;
  logic        ld;
  logic [31:0] nxt_mrd;
  logic [31:0] nxt_wdata;
  logic [4:0]  nxt_waddr;
  logic        nxt_exc;
  logic [31:0] retire_q;

  mem_wb_reg_load_ext #(.LDT_W(LDT_W)) u_ext (
    .word      (memReadData_MEM),
    .addr      (memAddr_MEM[1:0]),
    .loadType  (loadType_MEM),
    .ext       (ext),
    .misaligned(mis)
  );

  assign ld = is_load(3'(loadType_MEM));

  // Next-state WB values: a misaligned load or bubble suppresses the write;
  // writes to $0 always carry zero data.
  always_comb begin
    nxt_exc   = valid_MEM & mis;
    nxt_mrd   = mis ? 32'd0 : ext;
    nxt_waddr = (!valid_MEM || mis) ? 5'd0 : regWriteAddr_MEM;
    nxt_wdata = ld ? ext : regWriteData_MEM;
    if (mis || !valid_MEM || regWriteAddr_MEM == 5'd0)
      nxt_wdata = 32'd0;
  end

  // Pipeline register bank: reset > flush (bubble) > hold > capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_WB        <= '0;
      PC_WB           <= 32'd0;
      valid_WB        <= 1'b0;
      memReadData_WB  <= 32'd0;
      regWriteAddr_WB <= 5'd0;
      regWriteData_WB <= 32'd0;
      excAdEL_WB      <= 1'b0;
    end else if (en) begin
      instr_WB        <= instr_MEM;
      PC_WB           <= PC_MEM;
      valid_WB        <= valid_MEM;
      memReadData_WB  <= nxt_mrd;
      regWriteAddr_WB <= nxt_waddr;
      regWriteData_WB <= nxt_wdata;
      excAdEL_WB      <= nxt_exc;
    end
  end

  // Count instructions leaving WB, whether replaced by capture or by a bubble.
  always_ff @(posedge clk) begin
    if (reset)
      retire_q <= 32'd0;
    else if (valid_WB && (en || flush))
      retire_q <= retire_q + 32'd1;
  end

  assign retireCnt = retire_q;

endmodule
